uart_byte_tx: RTL and testbench

//   Serialises one byte per handshake onto the board's UART TX line (8 data bits, 1 stop bit, no flow control).

---
 rtl/uart_byte_tx.sv | 126 ++++++++++++
 tb/tb_uart_byte_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per valid/ready handshake onto the
// UART TX line: start bit, 8 data bits, optional parity, 1 stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame instead of 10).
//
// Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE; tx_valid while busy is ignored (no queueing).
// tx_data is only looked at on the accepting edge.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int MSB_FIRST    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       uart_tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_next;
   logic [BW-1:0]   baud_cnt, baud_next;
   logic [2:0]      bit_cnt, bit_next;
   logic [2:0]      data_idx;
   logic [7:0]      data_q;
   logic            load;
   logic            bit_end;
   logic            tx_q, tx_next;

   assign bit_end  = (baud_cnt == BAUD_LAST);
   assign tx_ready = (state == IDLE);
   assign tx_busy  = ~tx_ready;
   assign tx_done  = (state == STOP) && bit_end;
   assign uart_tx  = tx_q;

   // Data bit selected for the upcoming clk, following the configured bit order.
   assign data_idx = (MSB_FIRST != 0) ? (3'd7 - bit_next) : bit_next;

   // Next-state, counter and line-level decode; the line level is computed for
   // the next state so the registered uart_tx lines up with the state it belongs to.
   always_comb begin
      state_next = state;
      baud_next  = bit_end ? '0 : baud_cnt + BW'(1);
      bit_next   = bit_cnt;
      load       = 1'b0;
      case (state)
         IDLE: begin
            baud_next = '0;
            bit_next  = '0;
            if (tx_valid) begin
               load       = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == 3'd7) begin
                  bit_next = '0;
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
`endif
         STOP: begin
            if (bit_end) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            baud_next  = '0;
            bit_next   = '0;
         end
      endcase

      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = data_q[data_idx];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = ^data_q;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   // State, counters, latched byte and the registered serial line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         data_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         tx_q     <= tx_next;
         if (load) data_q <= tx_data;
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: one MSB-first and one LSB-first instance,
// bytes pushed to a scoreboard queue on handshake and popped per frame.
module tb_uart_byte_tx;
   localparam int CPB = 234;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic clk = 1'b0;
   logic reset;
   logic [7:0] msb_data, lsb_data;
   logic msb_valid, lsb_valid;
   logic msb_ready, msb_busy, msb_done, msb_tx;
   logic lsb_ready, lsb_busy, lsb_done, lsb_tx;
   logic sel;
   logic mon_tx, mon_ready, mon_busy, mon_done;

   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   // clock
   always #5 clk = ~clk;

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .reset(reset), .tx_data(msb_data), .tx_valid(msb_valid),
      .tx_ready(msb_ready), .tx_busy(msb_busy), .tx_done(msb_done), .uart_tx(msb_tx));

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .reset(reset), .tx_data(lsb_data), .tx_valid(lsb_valid),
      .tx_ready(lsb_ready), .tx_busy(lsb_busy), .tx_done(lsb_done), .uart_tx(lsb_tx));

   assign mon_tx    = sel ? lsb_tx    : msb_tx;
   assign mon_ready = sel ? lsb_ready : msb_ready;
   assign mon_busy  = sel ? lsb_busy  : msb_busy;
   assign mon_done  = sel ? lsb_done  : msb_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-clk valid pulse on the selected instance
   task automatic send(input logic [7:0] b, input bit push);
      chk("ready_before_send", {31'd0, mon_ready}, 32'd1);
      if (sel) begin lsb_data = b; lsb_valid = 1'b1; end
      else     begin msb_data = b; msb_valid = 1'b1; end
      tick();
      msb_valid = 1'b0;
      lsb_valid = 1'b0;
      if (push) exp_q.push_back(b);
   endtask

   // Called one sample after the handshake edge; checks every clk of the frame
   // and the idle clk that follows it.
   task automatic check_frame(input string tag, output logic [7:0] got, output logic got_par);
      logic [7:0]  b;
      logic [10:0] seq;
      int bad_line, done_cnt, done_at, j;
      bad_line = 0; done_cnt = 0; done_at = 0;
      got = '0; got_par = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
         return;
      end
      b = exp_q.pop_front();
      seq = '1;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[1 + i] = sel ? b[i] : b[7 - i];
`ifdef UART_TX_PARITY_EN
      seq[9] = ^b;
`endif
      chk({tag, "_ready_low"}, {31'd0, mon_ready}, 32'd0);
      chk({tag, "_busy_high"}, {31'd0, mon_busy}, 32'd1);
      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) tick();
         if (mon_tx !== seq[k / CPB]) bad_line++;
         if (mon_done === 1'b1) begin done_cnt++; done_at = k + 1; end
         if ((k % CPB) == CPB / 2) begin
            j = k / CPB;
            if (j >= 1 && j <= 8) got = sel ? {mon_tx, got[7:1]} : {got[6:0], mon_tx};
            if (NB == 11 && j == 9) got_par = mon_tx;
         end
      end
      chk({tag, "_line_bad_clks"}, bad_line, 0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_clk"}, done_at, FRAME);
      chk({tag, "_byte"}, {24'd0, got}, {24'd0, b});
      tick();
      chk({tag, "_idle_ready"}, {31'd0, mon_ready}, 32'd1);
      chk({tag, "_idle_tx"}, {31'd0, mon_tx}, 32'd1);
      chk({tag, "_idle_done"}, {31'd0, mon_done}, 32'd0);
   endtask

   initial begin
      logic [7:0] got;
      logic       par;
      int bad_tx, bad_rdy, bad_done;

      // reset block
      reset = 1'b1; sel = 1'b0;
      msb_valid = 1'b0; lsb_valid = 1'b0; msb_data = '0; lsb_data = '0;
      repeat (15) tick();
      chk("rst_msb_tx", {31'd0, msb_tx}, 32'd1);
      chk("rst_msb_ready", {31'd0, msb_ready}, 32'd1);
      chk("rst_msb_busy", {31'd0, msb_busy}, 32'd0);
      chk("rst_msb_done", {31'd0, msb_done}, 32'd0);
      chk("rst_lsb_tx", {31'd0, lsb_tx}, 32'd1);
      chk("rst_lsb_ready", {31'd0, lsb_ready}, 32'd1);
      reset = 1'b0;

      // idle with no valid
      bad_tx = 0; bad_rdy = 0; bad_done = 0;
      for (int k = 0; k < 10000; k++) begin
         tick();
         if (msb_tx !== 1'b1 || lsb_tx !== 1'b1) bad_tx++;
         if (msb_ready !== 1'b1 || lsb_ready !== 1'b1) bad_rdy++;
         if (msb_done !== 1'b0 || lsb_done !== 1'b0) bad_done++;
      end
      chk("idle_tx_bad", bad_tx, 0);
      chk("idle_ready_bad", bad_rdy, 0);
      chk("idle_done_bad", bad_done, 0);

      // 8'hAA MSB first
      sel = 1'b0;
      send(8'hAA, 1'b1);
      check_frame("aa_msb", got, par);

      // 8'hA5 LSB first, decoded as an LSB-first receiver would
      sel = 1'b1;
      send(8'hA5, 1'b1);
      check_frame("a5_lsb", got, par);
      chk("a5_lsb_loopback", {24'd0, got}, 32'h0000_00A5);
      sel = 1'b0;

      // back-to-back with valid held high; 8'h80 presented mid-frame
      msb_data = 8'h01; msb_valid = 1'b1;
      tick();
      exp_q.push_back(8'h01);
      msb_data = 8'h80;
      check_frame("b2b_first", got, par);
      tick();
      msb_valid = 1'b0;
      exp_q.push_back(8'h80);
      check_frame("b2b_second", got, par);

      // reset pulse during data bit 3 abandons the frame
      send(8'hC3, 1'b0);
      repeat (4 * CPB + 100) tick();
      chk("midrst_busy_before", {31'd0, msb_busy}, 32'd1);
      reset = 1'b1;
      tick();
      chk("midrst_tx_next_clk", {31'd0, msb_tx}, 32'd1);
      chk("midrst_ready", {31'd0, msb_ready}, 32'd1);
      bad_done = (msb_done === 1'b1) ? 1 : 0;
      repeat (99) begin
         tick();
         if (msb_done === 1'b1 || msb_tx !== 1'b1) bad_done++;
      end
      reset = 1'b0;
      tick();
      chk("midrst_hold_bad", bad_done, 0);
      chk("midrst_ready_after", {31'd0, msb_ready}, 32'd1);
      send(8'h5A, 1'b1);
      check_frame("after_rst_5a", got, par);

`ifdef UART_TX_PARITY_EN
      send(8'hA5, 1'b1);
      check_frame("par_a5", got, par);
      chk("par_a5_bit", {31'd0, par}, 32'd0);
      send(8'h07, 1'b1);
      check_frame("par_07", got, par);
      chk("par_07_bit", {31'd0, par}, 32'd1);
`endif

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
